// File: rtl/mem_port_arbiter_if.sv
// Shared data-memory port bundle: CPU MEM-stage side, camera writer side and the memory itself.
// The arbiter uses the slave modport; the environment (pipeline, camera, memory) uses master.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          cam_valid;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_wdata;
    logic          cam_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   cam_xfer_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cam_valid, cam_addr, cam_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, cam_ready,
        output mem_addr, mem_wdata, mem_we, cam_xfer_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cam_valid, cam_addr, cam_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, cam_ready,
        input  mem_addr, mem_wdata, mem_we, cam_xfer_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one data-memory port between the CPU MEM stage and a camera pixel writer with starvation relief.
// Optional macro CAM_BURST_EN: a forced camera grant extends into a BURST_LEN-transfer burst.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_LEN  = 4
) (
    input logic             clock,
    input logic             reset,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    if ($bits(bus.cpu_addr) != AW || $bits(bus.cpu_wdata) != DW) begin : g_width_check
        $error("mem_port_arbiter: interface widths do not match AW/DW");
    end
    if (BURST_LEN < 2 || BURST_LEN > 255) begin : g_burst_check
        $error("mem_port_arbiter: BURST_LEN must be within 2..255");
    end

    logic [SW-1:0] starve_cnt;
    logic [15:0]   xfer_cnt;
    logic          grant_cam;
    logic          in_burst;
    logic          forced;

    assign forced = bus.cpu_req && (starve_cnt == STARVE_LIMIT);

    // Reset masks the camera grant so the port falls back to plain CPU pass-through.
    always_comb begin
        grant_cam = 1'b0;
        if (!reset) begin
            grant_cam = bus.cam_valid && (!bus.cpu_req || forced || in_burst);
        end
    end

    assign bus.mem_addr     = grant_cam ? bus.cam_addr  : bus.cpu_addr;
    assign bus.mem_wdata    = grant_cam ? bus.cam_wdata : bus.cpu_wdata;
    assign bus.mem_we       = grant_cam ? 1'b1 : (!reset && bus.cpu_req && bus.cpu_we);
    assign bus.cam_ready    = grant_cam;
    assign bus.cpu_stall    = grant_cam && bus.cpu_req;
    assign bus.cpu_rdata    = bus.mem_rdata;
    assign bus.cam_xfer_cnt = xfer_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
            xfer_cnt   <= '0;
        end else begin
            if (grant_cam) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
            if (bus.cam_valid && !grant_cam) begin
                if (starve_cnt != STARVE_LIMIT) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

`ifdef CAM_BURST_EN
    typedef enum logic {
        CPU,
        BURST
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] burst_cnt;
    logic [7:0] burst_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CPU;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_next;
        end
    end

    // The forcing transfer itself counts as the first of the burst, hence the BURST_LEN-1 load.
    always_comb begin
        state_next = state;
        burst_next = burst_cnt;
        case (state)
            CPU: begin
                if (grant_cam && forced) begin
                    state_next = BURST;
                    burst_next = 8'(BURST_LEN - 1);
                end
            end
            BURST: begin
                if (!bus.cam_valid) begin
                    state_next = CPU;
                    burst_next = '0;
                end else if (grant_cam) begin
                    if (burst_cnt == 8'd1) begin
                        state_next = CPU;
                        burst_next = '0;
                    end else begin
                        burst_next = burst_cnt - 8'd1;
                    end
                end
            end
            default: begin
                state_next = CPU;
                burst_next = '0;
            end
        endcase
    end

    assign in_burst = (state == BURST);
`else
    assign in_burst = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations follow the CAM_BURST_EN setting of the build.
module tb_mem_port_arbiter;
    logic clock;
    logic reset;
    int   checks;
    int   passes;

    localparam logic [31:0] CPU_ADDR  = 32'h0000_1000;
    localparam logic [31:0] CPU_WDATA = 32'h1111_2222;
    localparam logic [31:0] CAM_ADDR  = 32'h8000_0040;
    localparam logic [31:0] CAM_WDATA = 32'hABCD_0123;
    localparam logic [31:0] RDATA     = 32'hCAFE_0001;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(4), .BURST_LEN(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic cpu_req, input logic cpu_we, input logic cam_valid);
        bus.cpu_req   = cpu_req;
        bus.cpu_we    = cpu_we;
        bus.cam_valid = cam_valid;
        #1;
    endtask

    // Forced-grant pattern with cpu_req and cam_valid held high from cycle 0.
    function automatic logic exp_ready(input int c);
`ifdef CAM_BURST_EN
        return (c % 8) >= 4;
`else
        return (c % 5) == 4;
`endif
    endfunction

    initial begin
        checks = 0;
        passes = 0;
        bus.cpu_addr  = CPU_ADDR;
        bus.cpu_wdata = CPU_WDATA;
        bus.cam_addr  = CAM_ADDR;
        bus.cam_wdata = CAM_WDATA;
        bus.mem_rdata = RDATA;
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b1);

        check_output("reset_cam_ready", 32'(bus.cam_ready), 32'd0);
        check_output("reset_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        check_output("reset_mem_we", 32'(bus.mem_we), 32'd0);
        check_output("reset_mem_addr", bus.mem_addr, CPU_ADDR);
        check_output("reset_mem_wdata", bus.mem_wdata, CPU_WDATA);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("post_reset_xfer_cnt", 32'(bus.cam_xfer_cnt), 32'd0);
        check_output("idle_mem_we", 32'(bus.mem_we), 32'd0);
        check_output("idle_mem_addr", bus.mem_addr, CPU_ADDR);

        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("cpu_wr_mem_we", 32'(bus.mem_we), 32'd1);
        check_output("cpu_wr_mem_wdata", bus.mem_wdata, CPU_WDATA);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("cpu_rd_mem_we", 32'(bus.mem_we), 32'd0);
        check_output("cpu_rd_rdata", bus.cpu_rdata, RDATA);
        check_output("cpu_rd_stall", 32'(bus.cpu_stall), 32'd0);

        // Camera alone for three cycles.
        apply_stimulus(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check_output($sformatf("cam_only_ready_c%0d", c), 32'(bus.cam_ready), 32'd1);
            check_output($sformatf("cam_only_addr_c%0d", c), bus.mem_addr, CAM_ADDR);
            check_output($sformatf("cam_only_we_c%0d", c), 32'(bus.mem_we), 32'd1);
            check_output($sformatf("cam_only_stall_c%0d", c), 32'(bus.cpu_stall), 32'd0);
            next_cycle();
        end
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("cam_only_xfer_cnt", 32'(bus.cam_xfer_cnt), 32'd3);

        // Contention: CPU reads continuously while the camera waits for relief.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 14; c++) begin
            check_output($sformatf("contend_ready_c%0d", c), 32'(bus.cam_ready), 32'(exp_ready(c)));
            check_output($sformatf("contend_stall_c%0d", c), 32'(bus.cpu_stall), 32'(exp_ready(c)));
            check_output($sformatf("contend_addr_c%0d", c), bus.mem_addr, exp_ready(c) ? CAM_ADDR : CPU_ADDR);
            check_output($sformatf("contend_we_c%0d", c), 32'(bus.mem_we), 32'(exp_ready(c)));
            next_cycle();
        end
`ifdef CAM_BURST_EN
        check_output("contend_xfer_cnt", 32'(bus.cam_xfer_cnt), 32'd6);
`else
        check_output("contend_xfer_cnt", 32'(bus.cam_xfer_cnt), 32'd2);
`endif

        // Reset landing on a camera grant (mid-burst when bursts are built in).
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b1);
`ifdef CAM_BURST_EN
        for (int c = 0; c < 6; c++) next_cycle();
`else
        for (int c = 0; c < 4; c++) next_cycle();
`endif
        check_output("pre_reset_ready", 32'(bus.cam_ready), 32'd1);
        reset = 1'b1;
        #1;
        check_output("mid_reset_ready", 32'(bus.cam_ready), 32'd0);
        check_output("mid_reset_stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_output("after_reset_ready", 32'(bus.cam_ready), 32'd0);
        check_output("after_reset_xfer_cnt", 32'(bus.cam_xfer_cnt), 32'd0);

        // Counter wrap.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 65535; c++) next_cycle();
        check_output("xfer_cnt_ffff", 32'(bus.cam_xfer_cnt), 32'h0000_FFFF);
        next_cycle();
        check_output("xfer_cnt_wrap", 32'(bus.cam_xfer_cnt), 32'h0000_0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
